// File: rtl/mf_pkg.sv
// Shared types and constants for the matched-filter peak detector and related blocks.
package mf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_REPORT
  } det_state_e;

  localparam int unsigned MF_WIDTH_DEFAULT = 40;
  localparam int unsigned MAG_WIDTH        = 2 * MF_WIDTH_DEFAULT + 1;
  localparam int unsigned DRAIN_CYCLES     = 2;

  // Width of |x|^2 for a signed component of the given width; sum of two squares never overflows.
  function automatic int unsigned mag_width(input int unsigned mf_width);
    return 2 * mf_width + 1;
  endfunction

endpackage

// File: rtl/mf_mag_squared.sv
// Two-stage Re^2 + Im^2 pipeline with valid and sample-index sideband.
module mf_mag_squared
  import mf_pkg::*;
#(
  parameter  int unsigned W  = 40,
  parameter  int unsigned IW = 19,
  localparam int unsigned MW = mag_width(W)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic signed [W-1:0]  re_i,
  input  logic signed [W-1:0]  im_i,
  input  logic        [IW-1:0] idx_i,
  output logic                 valid_o,
  output logic        [MW-1:0] mag_o,
  output logic        [IW-1:0] idx_o
);

  localparam int unsigned PW = 2 * W;

  logic signed [PW-1:0] re_sq_d;
  logic signed [PW-1:0] im_sq_d;
  logic        [PW-1:0] re_sq_q;
  logic        [PW-1:0] im_sq_q;
  logic                 s1_valid_q;
  logic        [IW-1:0] s1_idx_q;

  // Squares are non-negative, so the signed product reads directly as unsigned.
  assign re_sq_d = PW'(re_i) * PW'(re_i);
  assign im_sq_d = PW'(im_i) * PW'(im_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      re_sq_q    <= '0;
      im_sq_q    <= '0;
      valid_o    <= 1'b0;
      mag_o      <= '0;
      idx_o      <= '0;
    end else begin
      s1_valid_q <= valid_i & ~flush_i;
      valid_o    <= s1_valid_q & ~flush_i;
      if (valid_i) begin
        re_sq_q  <= $unsigned(re_sq_d);
        im_sq_q  <= $unsigned(im_sq_d);
        s1_idx_q <= idx_i;
      end
      if (s1_valid_q) begin
        mag_o <= {1'b0, re_sq_q} + {1'b0, im_sq_q};
        idx_o <= s1_idx_q;
      end
    end
  end

endmodule

// File: rtl/mf_peak_detector.sv
// Windowed peak search over matched-filter |x|^2 with a per-window latched threshold.
module mf_peak_detector
  import mf_pkg::*;
#(
  parameter  int unsigned MF_WIDTH      = 40,
  parameter  int unsigned WINDOW_LENGTH = 330000,
  parameter  int unsigned INDEX_WIDTH   = 19,
  localparam int unsigned MAG_W         = mag_width(MF_WIDTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [MF_WIDTH-1:0] MFOutputRe,
  input  logic signed [MF_WIDTH-1:0] MFOutputIm,
  input  logic                       MFOutputValid,
  input  logic [MAG_W-1:0]           threshold,
  output logic                       peakValid,
  output logic                       peakFound,
  output logic [MAG_W-1:0]           peakMag,
  output logic [INDEX_WIDTH-1:0]     peakIndex,
  output logic                       busy
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX  = INDEX_WIDTH'(WINDOW_LENGTH - 1);
  localparam logic [1:0]             DRAIN_END = 2'(DRAIN_CYCLES - 1);

  det_state_e             state_q;
  logic [INDEX_WIDTH-1:0] cnt_q;
  logic [1:0]             drain_q;
  logic [MAG_W-1:0]       thr_q;
  logic [MAG_W-1:0]       peak_mag_q;
  logic [INDEX_WIDTH-1:0] peak_idx_q;
  logic                   found_q;

  logic                   active_c;
  logic                   inject_c;
  logic                   flush_c;
  logic                   update_c;
  logic                   s2_valid;
  logic [MAG_W-1:0]       s2_mag;
  logic [INDEX_WIDTH-1:0] s2_idx;

  assign active_c = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
  assign inject_c = (state_q == ST_ACCUM) && enable && MFOutputValid;
  assign flush_c  = active_c && !enable;

  mf_mag_squared #(
    .W  (MF_WIDTH),
    .IW (INDEX_WIDTH)
  ) u_mag (
    .clk_i   (clock),
    .rst_ni  (reset),
    .flush_i (flush_c),
    .valid_i (inject_c),
    .re_i    (MFOutputRe),
    .im_i    (MFOutputIm),
    .idx_i   (cnt_q),
    .valid_o (s2_valid),
    .mag_o   (s2_mag),
    .idx_o   (s2_idx)
  );

  // Strict greater-than keeps the first occurrence on ties.
  assign update_c = s2_valid && active_c && (s2_mag >= thr_q) &&
                    (!found_q || (s2_mag > peak_mag_q));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      drain_q    <= '0;
      thr_q      <= '0;
      peak_mag_q <= '0;
      peak_idx_q <= '0;
      found_q    <= 1'b0;
      peakValid  <= 1'b0;
      peakFound  <= 1'b0;
      peakMag    <= '0;
      peakIndex  <= '0;
      busy       <= 1'b0;
    end else begin
      peakValid <= 1'b0;
      peakFound <= 1'b0;
      peakMag   <= '0;
      peakIndex <= '0;

      if (update_c) begin
        peak_mag_q <= s2_mag;
        peak_idx_q <= s2_idx;
        found_q    <= 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (enable) begin
            thr_q      <= threshold;
            cnt_q      <= '0;
            peak_mag_q <= '0;
            peak_idx_q <= '0;
            found_q    <= 1'b0;
            state_q    <= ST_ACCUM;
            busy       <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end else if (MFOutputValid) begin
            cnt_q <= cnt_q + INDEX_WIDTH'(1);
            if (cnt_q == LAST_IDX) begin
              state_q <= ST_DRAIN;
              drain_q <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end else if (drain_q == DRAIN_END) begin
            state_q <= ST_REPORT;
            busy    <= 1'b0;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        ST_REPORT: begin
          peakValid <= 1'b1;
          peakFound <= found_q;
          peakMag   <= found_q ? peak_mag_q : '0;
          peakIndex <= found_q ? peak_idx_q : '0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mf_peak_detector.sv
// Directed bench for mf_peak_detector with a window-level reference model and per-cycle compare.
module tb_mf_peak_detector;

  localparam int unsigned MFW = 8;
  localparam int unsigned WL  = 16;
  localparam int unsigned IW  = 5;
  localparam int unsigned MW  = 2 * MFW + 1;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  enable;
  logic signed [MFW-1:0] re_in;
  logic signed [MFW-1:0] im_in;
  logic                  vin;
  logic [MW-1:0]         thr_in;
  logic                  peakValid;
  logic                  peakFound;
  logic [MW-1:0]         peakMag;
  logic [IW-1:0]         peakIndex;
  logic                  busy;

  mf_peak_detector #(
    .MF_WIDTH      (MFW),
    .WINDOW_LENGTH (WL),
    .INDEX_WIDTH   (IW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .MFOutputRe    (re_in),
    .MFOutputIm    (im_in),
    .MFOutputValid (vin),
    .threshold     (thr_in),
    .peakValid     (peakValid),
    .peakFound     (peakFound),
    .peakMag       (peakMag),
    .peakIndex     (peakIndex),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  int pulses = 0;
  bit chk_en = 0;

  int win_re [WL];
  int win_im [WL];

  bit exp_pending = 0;
  int exp_edge = 0;
  bit exp_found;
  int exp_mag;
  int exp_idx;
  bit cap_found;
  int cap_mag;
  int cap_idx;

  bit cv;
  bit cf;
  int cm;
  int ci;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Every cycle: outputs are all zero except on the single predicted report cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      cv = exp_pending && (edge_cnt == exp_edge);
      cf = cv && exp_found;
      cm = cv ? exp_mag : 0;
      ci = cv ? exp_idx : 0;
      tests++;
      if (peakValid !== cv || peakFound !== cf || peakMag !== MW'(cm) || peakIndex !== IW'(ci)) begin
        fails++;
        $display("FAIL cycle_out edge %0d: got v=%0b f=%0b mag=%0d idx=%0d, want v=%0b f=%0b mag=%0d idx=%0d",
                 edge_cnt, peakValid, peakFound, peakMag, peakIndex, cv, cf, cm, ci);
      end
      if (peakValid === 1'b1) pulses++;
      if (cv) begin
        exp_pending = 0;
        cap_found   = peakFound;
        cap_mag     = int'(peakMag);
        cap_idx     = int'(peakIndex);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill(input int re, input int im);
    for (int i = 0; i < int'(WL); i++) begin
      win_re[i] = re;
      win_im[i] = im;
    end
  endtask

  // Assumes the DUT is idle; the threshold is scrambled afterwards to prove it was latched.
  task automatic start_window(input int thr);
    thr_in = MW'(thr);
    enable = 1'b1;
    vin    = 1'b0;
    tick();
    thr_in = MW'($urandom_range(0, 131071));
    check("busy_in_accum", int'(busy), 1);
  endtask

  task automatic feed(input int re, input int im);
    re_in = MFW'(re);
    im_in = MFW'(im);
    vin   = 1'b1;
    tick();
    vin   = 1'b0;
  endtask

  task automatic gap_cycle();
    re_in = MFW'($urandom_range(0, 255));
    im_in = MFW'($urandom_range(0, 255));
    vin   = 1'b0;
    tick();
  endtask

  task automatic run_window(input string name, input int thr, input bit gappy,
                            input bit want_found, input int want_mag, input int want_idx);
    bit mf;
    int mm;
    int mi;
    int m;
    int n;
    int guard;
    bit v;
    mf = 0; mm = 0; mi = 0;
    for (int i = 0; i < int'(WL); i++) begin
      m = win_re[i] * win_re[i] + win_im[i] * win_im[i];
      if (m >= thr && (!mf || m > mm)) begin
        mf = 1; mm = m; mi = i;
      end
    end
    check({name, "_model_found"}, int'(mf), int'(want_found));
    check({name, "_model_mag"}, mf ? mm : 0, want_mag);
    check({name, "_model_idx"}, mf ? mi : 0, want_idx);

    start_window(thr);
    n = 0;
    for (int c = 0; c < (gappy ? 40 : int'(WL)); c++) begin
      if (!gappy || n == int'(WL)) v = (n < int'(WL));
      else if (int'(WL) - n == 40 - c) v = 1;
      else v = 1'($urandom_range(0, 1));
      if (v) begin
        feed(win_re[n], win_im[n]);
        n++;
        if (n == int'(WL)) begin
          exp_found   = mf;
          exp_mag     = mf ? mm : 0;
          exp_idx     = mf ? mi : 0;
          exp_edge    = edge_cnt + 3;
          exp_pending = 1;
        end
      end else begin
        gap_cycle();
      end
    end
    guard = 0;
    while (exp_pending && guard < 20) begin
      tick();
      guard++;
    end
    check({name, "_report_seen"}, int'(exp_pending), 0);
    exp_pending = 0;
    check({name, "_restart_busy"}, int'(busy), 1);
    enable = 1'b0;
    tick();
    tick();
    check({name, "_idle_busy"}, int'(busy), 0);
    check({name, "_dut_found"}, int'(cap_found), int'(want_found));
    check({name, "_dut_mag"}, cap_mag, want_mag);
    check({name, "_dut_idx"}, cap_idx, want_idx);
  endtask

  int pulses_before;

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    vin    = 1'b1;
    re_in  = 8'sd5;
    im_in  = 8'sd5;
    thr_in = '0;
    tick();
    tick();
    chk_en = 1;
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(peakValid), 0);
    enable = 1'b0;
    vin    = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    check("post_reset_busy", int'(busy), 0);

    // single peak
    fill(1, 1); win_re[7] = 10; win_im[7] = -5;
    run_window("single", 100, 0, 1, 125, 7);
    // threshold exactly equal to the peak still counts
    run_window("thr_equal", 125, 0, 1, 125, 7);
    // largest legal magnitude on the last index
    fill(1, 1); win_re[15] = -128; win_im[15] = -128;
    run_window("max_last", 32768, 0, 1, 32768, 15);
    // tie: first occurrence wins
    fill(5, 5); win_re[3] = -128; win_im[3] = 0; win_re[9] = -128; win_im[9] = 0;
    run_window("tie", 0, 0, 1, 16384, 3);
    // below threshold
    fill(1, 2); win_re[4] = 20; win_im[4] = 20;
    run_window("below", 1000, 0, 0, 0, 0);
    // gappy valid
    fill(3, 4); win_re[11] = 0; win_im[11] = 50;
    run_window("gappy", 0, 1, 1, 2500, 11);

    // abort after 8 samples, then a full window
    pulses_before = pulses;
    start_window(0);
    for (int i = 0; i < 8; i++) feed(127, 127);
    enable = 1'b0;
    tick();
    tick();
    check("abort_busy", int'(busy), 0);
    fill(2, 2); win_re[2] = 30; win_im[2] = 0;
    run_window("after_abort", 0, 0, 1, 900, 2);
    check("abort_one_pulse", pulses - pulses_before, 1);

    // mid-window reset at sample 5
    pulses_before = pulses;
    start_window(0);
    for (int i = 0; i < 5; i++) feed(100, 100);
    re_in  = 8'sd100;
    im_in  = 8'sd100;
    vin    = 1'b1;
    enable = 1'b0;
    reset  = 1'b0;
    tick();
    vin   = 1'b0;
    reset = 1'b1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_valid", int'(peakValid), 0);
    check("midreset_mag", int'(peakMag), 0);
    repeat (6) tick();
    check("midreset_no_report", pulses - pulses_before, 0);
    fill(1, 1); win_re[0] = 7; win_im[0] = 7;
    run_window("after_reset", 50, 0, 1, 98, 0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
